vga_scan_reader: RTL and testbench



---
 rtl/vga_scan_reader.sv | 130 +++++++++++++
 tb/tb_vga_scan_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_reader.sv
// Display-side frame RAM reader: 640x480@60 VGA timing at half the system clock.
// Each stored pixel is repeated over a 2^SCALE_SHIFT square of screen pixels, and the result is registered as RGB332.
module vga_scan_reader #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          SCALE_SHIFT = 2,
    parameter int          FB_WIDTH    = 160,
    parameter logic [23:0] BASE_ADDR   = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [23:0] vga_address,
    input  logic [15:0] vga_data,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        video_on,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [23:0] FB_W     = 24'(FB_WIDTH);

    logic        tick_q, tick_d;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [23:0] addr_q, addr_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [2:0]  red_q, red_d;
    logic [2:0]  green_q, green_d;
    logic [1:0]  blue_q, blue_d;
    logic        video_on_q, video_on_d;
    logic        frame_start_q, frame_start_d;

    logic        visible;
    logic [23:0] pix_addr;
    logic        unused_hi;

    assign visible   = (h_q < H_VIS) && (v_q < V_VIS);
    assign pix_addr  = BASE_ADDR + 24'(v_q >> SCALE_SHIFT) * FB_W + 24'(h_q >> SCALE_SHIFT);
    assign unused_hi = ^vga_data[15:8];

    always_comb begin
        tick_d        = ~tick_q;
        h_d           = h_q;
        v_d           = v_q;
        addr_d        = addr_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        video_on_d    = video_on_q;
        frame_start_d = 1'b0;

        if (!tick_q) begin
            // Pixel edge: h_q/v_q still describe the pixel whose read data is now on vga_data.
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            hsync_d       = !((h_q >= HS_START) && (h_q < HS_END));
            vsync_d       = !((v_q >= VS_START) && (v_q < VS_END));
            video_on_d    = visible;
            red_d         = visible ? vga_data[7:5] : 3'd0;
            green_d       = visible ? vga_data[4:2] : 3'd0;
            blue_d        = visible ? vga_data[1:0] : 2'd0;
            frame_start_d = (h_q == '0) && (v_q == '0);
        end else begin
            addr_d = visible ? pix_addr : BASE_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q        <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            addr_q        <= BASE_ADDR;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            h_q           <= h_d;
            v_q           <= v_d;
            addr_q        <= addr_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_address = addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scan_reader.sv
// Bench for vga_scan_reader: full-size instances for addressing/colour/line timing,
// and a shrunken-timing instance whose every pixel is scoreboarded over many frames.
module tb_vga_scan_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- full-size instance, BASE_ADDR = 0 ----------------
    logic [23:0] a_addr;
    logic [15:0] a_data;
    logic a_hs, a_vs, a_von, a_fs;
    logic [2:0] a_r, a_g;
    logic [1:0] a_b;
    assign a_data = (a_addr == 24'd0) ? 16'hFFE3 : 16'h00FF;

    vga_scan_reader dut_a (
        .clk(clk), .reset(reset), .vga_address(a_addr), .vga_data(a_data),
        .hsync(a_hs), .vsync(a_vs), .red(a_r), .green(a_g), .blue(a_b),
        .video_on(a_von), .frame_start(a_fs));

    // ---------------- full-size instance, BASE_ADDR = 0x4000 ----------------
    logic [23:0] b_addr;
    logic [15:0] b_data;
    logic b_hs, b_vs, b_von, b_fs;
    logic [2:0] b_r, b_g;
    logic [1:0] b_b;
    assign b_data = 16'h1234;

    vga_scan_reader #(.BASE_ADDR(24'h004000)) dut_b (
        .clk(clk), .reset(reset), .vga_address(b_addr), .vga_data(b_data),
        .hsync(b_hs), .vsync(b_vs), .red(b_r), .green(b_g), .blue(b_b),
        .video_on(b_von), .frame_start(b_fs));

    // ---------------- small-timing instance: 24 x 12 pixel frame ----------------
    localparam int S_HT = 24;
    localparam int S_VT = 12;
    localparam int S_FRAME = S_HT * S_VT;

    function automatic logic [15:0] ram_s(input logic [23:0] a);
        logic [7:0] lo;
        lo = (a[7:0] * 8'd53) ^ 8'h96;
        return {a[15:8], lo};
    endfunction

    logic [23:0] s_addr;
    logic [15:0] s_data;
    logic s_hs, s_vs, s_von, s_fs;
    logic [2:0] s_r, s_g;
    logic [1:0] s_b;
    assign s_data = ram_s(s_addr);

    vga_scan_reader #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SCALE_SHIFT(1), .FB_WIDTH(8), .BASE_ADDR(24'h000100)) dut_s (
        .clk(clk), .reset(reset), .vga_address(s_addr), .vga_data(s_data),
        .hsync(s_hs), .vsync(s_vs), .red(s_r), .green(s_g), .blue(s_b),
        .video_on(s_von), .frame_start(s_fs));

    // Expected {hsync, vsync, video_on, frame_start, rgb332} for linear pixel n of the small frame.
    function automatic logic [11:0] exp_s(input int n);
        int h, v;
        logic vis;
        logic [23:0] a;
        logic [15:0] d;
        h = n % S_HT;
        v = n / S_HT;
        vis = (h < 16) && (v < 8);
        a = 24'h000100 + 24'((v >> 1) * 8 + (h >> 1));
        d = ram_s(a);
        return {!(h >= 18 && h < 22), !(v >= 9 && v < 11), vis, (n == 0), vis ? d[7:0] : 8'h00};
    endfunction

    logic [11:0] sb_q[$];
    bit sb_en = 1'b0;
    bit m_tick = 1'b0;
    int m_n = 0;

    // Pixel-rate model: each tick edge pushes the pixel the DUT must present after that edge.
    always @(posedge clk) begin
        if (reset) begin
            m_tick = 1'b0;
            m_n = 0;
            sb_q.delete();
        end else begin
            if (!m_tick) begin
                sb_q.push_back(exp_s(m_n));
                m_n = (m_n + 1) % S_FRAME;
            end
            m_tick = !m_tick;
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            if (sb_q.size() > 0) begin
                logic [11:0] e;
                e = sb_q.pop_front();
                check("pix_s", {s_hs, s_vs, s_von, s_fs, s_r, s_g, s_b}, e);
            end else begin
                check("fs_s_low", s_fs, 1'b0);
            end
        end
    end

    // ---------------- vector table for the full-size instances ----------------
    // c = number of clk edges since reset release; sel: 0 a_addr, 1 b_addr, 2 a {von,hs,vs,rgb}, 3 a_fs
    typedef struct {
        int          c;
        int          sel;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input int c, input int sel, input logic [31:0] exp, input string name);
        vec_t v;
        v.c = c; v.sel = sel; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_a_hs"}, a_hs, 1'b1);
        check({tag, "_a_vs"}, a_vs, 1'b1);
        check({tag, "_a_rgb"}, {a_r, a_g, a_b}, 8'h00);
        check({tag, "_a_von"}, a_von, 1'b0);
        check({tag, "_a_fs"}, a_fs, 1'b0);
        check({tag, "_a_addr"}, a_addr, 24'h000000);
        check({tag, "_b_addr"}, b_addr, 24'h004000);
        check({tag, "_s_hs"}, s_hs, 1'b1);
        check({tag, "_s_addr"}, s_addr, 24'h000100);
    endtask

    int vi = 0;
    int hs_low = 0, vs_low = 0, fs_cnt = 0;
    int hs_fall0 = -1, hs_fall1 = -1, fs0 = -1, fs1 = -1;
    logic prev_hs = 1'b1;
    logic [31:0] act;

    initial begin
        add(1,     2, 32'h7E3,    "pix_0_0");
        add(1,     3, 32'h1,      "fs_first");
        add(2,     0, 32'h0,      "addr_1_0");
        add(2,     2, 32'h7E3,    "pix_0_0_hold");
        add(2,     3, 32'h0,      "fs_one_clk");
        add(7,     2, 32'h7E3,    "pix_3_0");
        add(9,     2, 32'h7FF,    "pix_4_0");
        add(10,    0, 32'h1,      "addr_5_0");
        add(10,    1, 32'h4001,   "addr_b_5_0");
        add(1278,  0, 32'd159,    "addr_639_0");
        add(1280,  0, 32'h0,      "addr_640_0");
        add(1280,  1, 32'h4000,   "addr_b_640_0");
        add(1281,  2, 32'h300,    "pix_640_0");
        add(1313,  2, 32'h100,    "pix_656_0");
        add(1503,  2, 32'h100,    "pix_751_0");
        add(1505,  2, 32'h300,    "pix_752_0");
        add(1601,  2, 32'h7E3,    "pix_0_1");
        add(4807,  2, 32'h7E3,    "pix_3_3");
        add(6401,  2, 32'h7FF,    "pix_0_4");
        add(6408,  0, 32'd161,    "addr_4_4");
        add(14410, 0, 32'd321,    "addr_5_9");
        add(14410, 1, 32'h4141,   "addr_b_5_9");
        add(15678, 0, 32'd479,    "addr_639_9");
        add(15680, 0, 32'h0,      "addr_640_9");

        repeat (3) @(negedge clk);
        sb_en = 1'b1;
        check_reset("rst0");
        reset = 1'b0;

        for (int c = 1; c <= 16000; c++) begin
            @(negedge clk);
            if (c <= 1600 && !a_hs) hs_low++;
            if (prev_hs && !a_hs) begin
                if (hs_fall0 < 0) hs_fall0 = c;
                else if (hs_fall1 < 0) hs_fall1 = c;
            end
            prev_hs = a_hs;
            if (c <= S_FRAME * 2) begin
                if (!s_vs) vs_low++;
                if (s_fs) fs_cnt++;
            end
            if (s_fs) begin
                if (fs0 < 0) fs0 = c;
                else if (fs1 < 0) fs1 = c;
            end
            while (vi < vecs.size() && vecs[vi].c == c) begin
                case (vecs[vi].sel)
                    0:       act = 32'(a_addr);
                    1:       act = 32'(b_addr);
                    2:       act = {21'd0, a_von, a_hs, a_vs, a_r, a_g, a_b};
                    default: act = 32'(a_fs);
                endcase
                check(vecs[vi].name, act, vecs[vi].exp);
                vi++;
            end
        end
        check("vectors_applied", vi, vecs.size());
        check("hs_low_clks", hs_low, 192);
        check("hs_first_fall", hs_fall0, 1313);
        check("line_period", hs_fall1 - hs_fall0, 1600);
        check("vs_low_clks_s", vs_low, 96);
        check("fs_pulses_s", fs_cnt, 1);
        check("fs_first_s", fs0, 1);
        check("frame_period_s", fs1 - fs0, 2 * S_FRAME);

        // Reset in the middle of line 10's hsync pulse.
        repeat (1400) @(negedge clk);
        check("hs_before_rst", a_hs, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset("rst1");
        repeat (2) @(negedge clk);
        check_reset("rst3");
        reset = 1'b0;
        @(negedge clk);
        check("restart_fs", a_fs, 1'b1);
        check("restart_von", a_von, 1'b1);
        check("restart_hs", a_hs, 1'b1);
        repeat (1200) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
